// File: rtl/dec_pkg.sv
// Shared types and helpers for the decoder frame checker.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } dec_chk_state_t;

  // Counter width able to hold 0..frame_len inclusive.
  function automatic int calc_cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/dec_err_counter.sv
// Up-counter with synchronous clear (priority) and increment enable.
module dec_err_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dec_frame_checker.sv
// Frame-level compare of decoded vs golden words; reports mismatch count and pass flag.
// Optional DEC_FRAME_FIRST_ERR_EN adds first_err_idx (index of first mismatching word).
module dec_frame_checker
  import dec_pkg::*;
#(
  parameter  int DATA_DEPTH = 8,
  parameter  int FRAME_LEN  = 16,
  localparam int CNT_W      = calc_cnt_w(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_DEPTH-1:0] data_a,
  input  logic [DATA_DEPTH-1:0] data_b,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  frame_ok
`ifdef DEC_FRAME_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]      first_err_idx
`endif
);

  dec_chk_state_t   r_state;
  logic [CNT_W-1:0] w_word_cnt;
  logic [CNT_W-1:0] w_err_acc;
  logic             w_run;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_abort_run;
  logic             w_start_idle;
  logic             w_clr;
  logic             w_last;

  assign w_run        = (r_state == RUN);
  assign in_ready     = w_run;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == REPORT);

  assign w_accept     = in_valid && w_run;
  assign w_mismatch   = (data_a !== data_b);
  assign w_abort_run  = w_run && abort;
  assign w_start_idle = (r_state == IDLE) && start;
  // Clear has priority in the counters, so an abort on the last beat leaves nothing behind.
  assign w_clr        = w_start_idle || w_abort_run;
  assign w_last       = w_accept && (w_word_cnt == CNT_W'(FRAME_LEN - 1));

  dec_err_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_accept),
    .cnt (w_word_cnt)
  );

  dec_err_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_accept && w_mismatch),
    .cnt (w_err_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      err_cnt  <= '0;
      frame_ok <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) r_state <= RUN;
        end
        RUN: begin
          if (abort)       r_state <= IDLE;
          else if (w_last) r_state <= REPORT;
        end
        REPORT: begin
          err_cnt  <= w_err_acc;
          frame_ok <= (w_err_acc == '0);
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DEC_FRAME_FIRST_ERR_EN
  logic [CNT_W-1:0] r_first_idx;

  // A zero error accumulator marks the first mismatch of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_idx   <= '0;
      first_err_idx <= '0;
    end else begin
      if (w_clr) begin
        r_first_idx <= '0;
      end else if (w_accept && w_mismatch && (w_err_acc == '0)) begin
        r_first_idx <= w_word_cnt;
      end
      if (r_state == REPORT) first_err_idx <= r_first_idx;
    end
  end
`endif

endmodule

// File: tb/tb_dec_frame_checker.sv
// Directed self-checking bench for dec_frame_checker (FRAME_LEN=16, DATA_DEPTH=8).
module tb_dec_frame_checker;

  localparam int DW = 8;
  localparam int FL = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_cnt;
  logic          frame_ok;
`ifdef DEC_FRAME_FIRST_ERR_EN
  logic [CW-1:0] first_err_idx;
`endif

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  dec_frame_checker #(.DATA_DEPTH(DW), .FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_a   (data_a),
    .data_b   (data_b),
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt),
    .frame_ok (frame_ok)
`ifdef DEC_FRAME_FIRST_ERR_EN
    ,
    .first_err_idx (first_err_idx)
`endif
  );

  always @(negedge clk) if (done === 1'b1) done_seen++;

  typedef struct {
    string       name;
    logic [15:0] mask;
    logic        gaps;
    int          exp_err;
    logic        exp_ok;
    int          exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic mm, input logic with_abort);
    in_valid = 1'b1;
    data_a   = 8'($urandom());
    data_b   = mm ? (data_a ^ 8'h5A) : data_a;
    abort    = with_abort;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic frame_body(input logic [15:0] mask, input logic gaps);
    for (int i = 0; i < FL; i++) begin
      if (gaps) begin
        int ng;
        ng = int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          in_valid = 1'b0;
          data_a = 8'h00;
          data_b = 8'hFF;
          tick();
        end
      end
      if (i == 0) check("run_ready", in_ready, 1'b1);
      if (i == FL - 1) check("no_early_done", done, 1'b0);
      beat(mask[i], 1'b0);
    end
    check("report_done", done, 1'b1);
    check("report_ready", in_ready, 1'b0);
  endtask

  task automatic finish_frame(input string nm, input int e_err, input logic e_ok, input int e_first);
    tick();
    check({nm, "_done_fall"}, done, 1'b0);
    check({nm, "_busy"}, busy, 1'b0);
    check({nm, "_err_cnt"}, err_cnt, e_err);
    check({nm, "_frame_ok"}, frame_ok, e_ok);
    check({nm, "_done_count"}, done_seen, 1);
`ifdef DEC_FRAME_FIRST_ERR_EN
    check({nm, "_first_err"}, first_err_idx, e_first);
`else
    if (e_first < 0) check({nm, "_first_err_arg"}, e_first, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{"clean",     16'h0000, 1'b0, 0,  1'b1, 0};
    vecs[1] = '{"err_3_7_15", 16'h8088, 1'b0, 3,  1'b0, 3};
    vecs[2] = '{"all_err",   16'hFFFF, 1'b1, 16, 1'b0, 0};
    vecs[3] = '{"first_only", 16'h0001, 1'b0, 1,  1'b0, 0};
    vecs[4] = '{"last_only", 16'h8000, 1'b1, 1,  1'b0, 15};
    vecs[5] = '{"mid_nibble", 16'h00F0, 1'b1, 4,  1'b0, 4};

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    data_a = '0; data_b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_ok", frame_ok, 1'b0);
`ifdef DEC_FRAME_FIRST_ERR_EN
    check("rst_first_err", first_err_idx, 0);
`endif

    for (int v = 0; v < 6; v++) begin
      done_seen = 0;
      start_frame();
      check({vecs[v].name, "_busy_run"}, busy, 1'b1);
      frame_body(vecs[v].mask, vecs[v].gaps);
      finish_frame(vecs[v].name, vecs[v].exp_err, vecs[v].exp_ok, vecs[v].exp_first);
    end

    // Beats offered in IDLE must be ignored.
    in_valid = 1'b1; data_a = 8'h12; data_b = 8'h34;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", in_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    in_valid = 1'b0;
    done_seen = 0;
    start_frame();
    frame_body(16'h0000, 1'b1);
    finish_frame("idle_ignored", 0, 1'b1, 0);

    // Previous frame result: 2 errors, first at 9.
    done_seen = 0;
    start_frame();
    frame_body(16'h0600, 1'b0);
    finish_frame("pre_abort", 2, 1'b0, 9);

    // Abort on the final beat wins over REPORT.
    done_seen = 0;
    start_frame();
    for (int i = 0; i < FL - 1; i++) beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    tick();
    check("abort_err_kept", err_cnt, 2);
    check("abort_ok_kept", frame_ok, 1'b0);
    check("abort_no_done", done_seen, 0);
`ifdef DEC_FRAME_FIRST_ERR_EN
    check("abort_first_kept", first_err_idx, 9);
`endif

    // Abort in IDLE is ignored; start+abort in IDLE starts.
    abort = 1'b1;
    tick();
    check("idle_abort_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("mid_abort_busy", busy, 1'b0);
    done_seen = 0;
    start_frame();
    frame_body(16'h0004, 1'b0);
    finish_frame("after_abort", 1, 1'b0, 2);

    // Reset mid-frame.
    start_frame();
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_ready", in_ready, 1'b0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_frame_ok", frame_ok, 1'b0);
`ifdef DEC_FRAME_FIRST_ERR_EN
    check("mrst_first_err", first_err_idx, 0);
`endif
    done_seen = 0;
    start_frame();
    frame_body(16'h0000, 1'b0);
    finish_frame("post_rst", 0, 1'b1, 0);

    // start held through RUN and REPORT, then back-to-back second frame.
    done_seen = 0;
    start = 1'b1;
    tick();
    frame_body(16'h0102, 1'b0);
    tick();
    check("b2b1_err_cnt", err_cnt, 2);
    check("b2b1_frame_ok", frame_ok, 1'b0);
    check("b2b1_done_count", done_seen, 1);
`ifdef DEC_FRAME_FIRST_ERR_EN
    check("b2b1_first_err", first_err_idx, 1);
`endif
    tick();
    start = 1'b0;
    check("b2b2_busy", busy, 1'b1);
    done_seen = 0;
    frame_body(16'h0000, 1'b1);
    finish_frame("b2b2", 0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_frame_checker.md
Name: dec_frame_checker

Overview:
- Frame-level check controller for the decoder path.
- Accepts pairs of words (decoded output, golden/original data) over a valid/ready handshake and compares each pair with a per-word equality compare.
- Counts mismatches over a fixed-length frame, then reports an error count and a pass/fail flag.
- Sits after the decoder in the loopback/self-test path and is driven by the test sequencer through start/abort.

Parameters:
- DATA_DEPTH, 8, width of each compared word.
- FRAME_LEN, 16, words per frame; legal range is 1 or more.
- CNT_W, $clog2(FRAME_LEN+1), width of the error and word counters. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  cancel the frame in progress; honoured only in RUN.
- in_valid  in  1  data_a/data_b pair valid.
- in_ready  out  1  block can accept a pair.
- data_a  in  DATA_DEPTH  decoded word.
- data_b  in  DATA_DEPTH  golden word.
- busy  out  1  high in RUN and REPORT.
- done  out  1  one-cycle pulse when the frame result is valid.
- err_cnt  out  CNT_W  number of mismatching words in the last completed frame.
- frame_ok  out  1  high when the last completed frame had err_cnt==0.
- first_err_idx  out  CNT_W  only present with DEC_FRAME_FIRST_ERR_EN.

Behaviour:
- One clock domain. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, err_cnt=0, frame_ok=0, word counter=0, first_err_idx=0.
- FSM states: IDLE, RUN, REPORT.
  - IDLE: in_ready=0; in_valid is ignored. On start=1, go to RUN next cycle and clear the word and error counters. err_cnt/frame_ok keep the previous frame's result until REPORT overwrites them.
  - RUN: in_ready=1 combinationally from state.
    - A beat is accepted on a clk edge where in_valid&&in_ready.
    - Mismatch = (data_a !== data_b), 4-state case inequality; any X/Z difference counts as a mismatch in simulation.
    - Accepted mismatch: error counter += 1 on the same edge. Accepted beat: word counter += 1.
    - When the accepted beat is word FRAME_LEN-1, go to REPORT.
    - No beat is lost across the RUN->REPORT transition, because in_ready drops in REPORT.
  - REPORT: one cycle.
    - in_ready=0, done=1.
    - err_cnt <= error counter, frame_ok <= (error counter==0), registered on the exit edge.
    - Next state is IDLE. Outputs hold until the next REPORT or rst.
  - Output timing: err_cnt/frame_ok are valid from the cycle after done and stay stable. Verification samples them once done has fallen.
- Latency: last accepted beat edge -> done high next cycle -> results valid the cycle after.
- Error counter cannot exceed FRAME_LEN, so CNT_W is sufficient and no saturation logic is needed.
- start in RUN or REPORT is ignored.
- abort in RUN: return to IDLE next edge, no done, err_cnt/frame_ok unchanged, internal counters cleared.
- Simultaneous abort and last beat: abort wins; no done.
- abort outside RUN is ignored. start and abort together in IDLE: start honoured.
- rst mid-frame: all state returns to reset values on that edge; partial results are discarded.
- FRAME_LEN=1: RUN lasts until one beat is accepted, then REPORT.

Optional Feature:
- Macro: DEC_FRAME_FIRST_ERR_EN.
- Defined:
  - Adds the first_err_idx port and register.
  - Records the word index (0-based) of the first mismatching beat of the frame.
  - Published in REPORT alongside err_cnt.
  - Equals 0 when frame_ok=1. Cleared by rst; preserved on abort.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package dec_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, REPORT} dec_chk_state_t.
  - Localparam helper for the CNT_W derivation.
- One sub-module: dec_err_counter.
  - CNT_W-wide counter with synchronous clear and increment enable.
  - Instantiated twice: word count and error count.

Test Plan:
- FRAME_LEN=16, start, 16 beats with data_a==data_b -> done pulses once, 1 cycle after the 16th beat; err_cnt=0, frame_ok=1.
- 16 beats, mismatches at indices 3, 7, 15 -> err_cnt=3, frame_ok=0, first_err_idx=3 (with macro).
- in_valid toggled randomly with gaps and in_valid=1 in IDLE -> only RUN beats counted; exactly 16 accepted; IDLE beats ignored.
- abort asserted on the edge of the 16th beat -> no done, FSM returns to IDLE; err_cnt/frame_ok retain the prior frame's values.
- rst asserted after 5 beats -> all outputs at reset values next cycle; a new start plus 16 equal beats gives err_cnt=0.
- start pulsed during RUN and REPORT -> ignored; back-to-back frames (start the cycle after done) both report correctly, with a single done each.
